// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX->MEM pipeline stage register with a valid/ready handshake
// and a one-entry skid, so up to two beats are held. in_ready is registered,
// which removes any combinational path from out_ready back to EX.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global chip-ready; 0 freezes every flop (rst still wins)
//   flush           drop every held beat and any beat offered this cycle
//   in_*            EX side: valid/ready plus rd_data, rd_addr, mem_addr, op
//   out_*           MEM side: valid/ready plus the held beat (bubble when empty)
//   occupancy       number of beats held, 0..2
//
// Optional macro EX_MEM_PERF_EN adds:
//   stall_cnt (32)  cycles with out_valid & !out_ready while rdy
//   flush_cnt (16)  cycles with flush while rdy
module ex_mem_skid #(
  parameter int unsigned REG_W      = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned OP_W       = 6,
  parameter int unsigned NOP_OP     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_W-1:0]      in_rd_data,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [ADDR_W-1:0]     in_mem_addr,
  input  logic [OP_W-1:0]       in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_W-1:0]      out_rd_data,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [ADDR_W-1:0]     out_mem_addr,
  output logic [OP_W-1:0]       out_op,
`ifdef EX_MEM_PERF_EN
  output logic [31:0]           stall_cnt,
  output logic [15:0]           flush_cnt,
`endif
  output logic [1:0]            occupancy
);

  typedef struct packed {
    logic [REG_W-1:0]      rd_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [OP_W-1:0]       op;
  } beat_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  // An empty main register presents this, so a consumer ignoring out_valid writes x0.
  localparam beat_t BUBBLE = '{rd_data: '0, rd_addr: '0, mem_addr: '0, op: OP_W'(NOP_OP)};

  state_e state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  beat_t  in_beat;
  logic   in_fire;
  logic   out_fire;

  assign in_beat  = '{rd_data: in_rd_data, rd_addr: in_rd_addr,
                      mem_addr: in_mem_addr, op: in_op};
  assign in_fire  = in_valid & in_ready_q & rdy;
  assign out_fire = out_valid_q & out_ready & rdy;

  // Next-state and storage update; rdy=0 holds everything, flush beats the handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (rdy) begin
      if (flush) begin
        state_d = S_EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end else begin
        unique case (state_q)
          S_EMPTY: begin
            if (in_fire) begin
              state_d = S_ONE;
              main_d  = in_beat;
            end
          end
          S_ONE: begin
            if (in_fire && out_fire) begin
              main_d = in_beat;
            end else if (out_fire) begin
              state_d = S_EMPTY;
              main_d  = BUBBLE;
            end else if (in_fire) begin
              state_d = S_TWO;
              skid_d  = in_beat;
            end
          end
          S_TWO: begin
            // in_ready is low here, so only the drain can happen; skid is older than any new beat.
            if (out_fire) begin
              state_d = S_ONE;
              main_d  = skid_q;
              skid_d  = BUBBLE;
            end
          end
          default: begin
            state_d = S_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
          end
        endcase
      end
    end
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_rd_data  = main_q.rd_data;
  assign out_rd_addr  = main_q.rd_addr;
  assign out_mem_addr = main_q.mem_addr;
  assign out_op       = main_q.op;
  assign occupancy    = state_q;

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Wrapping event counters, frozen while rdy=0.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rdy && out_valid_q && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
    if (rdy && flush)                     flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: stimulus pushes expected beats, a negedge
// monitor pops and compares on every MEM-side handshake.
module tb_ex_mem_skid;

  typedef struct packed {
    logic [31:0] rd_data;
    logic [4:0]  rd_addr;
    logic [31:0] mem_addr;
    logic [5:0]  op;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_rd_data;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_mem_addr;
  logic [5:0]  in_op;
  logic        out_valid, out_ready;
  logic [31:0] out_rd_data;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_mem_addr;
  logic [5:0]  out_op;
  logic [1:0]  occupancy;
`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int    total = 0;
  int    bad   = 0;
  beat_t sb[$];
  beat_t mon_exp, mon_got;

  always #5 clk = ~clk;

  ex_mem_skid dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd_data   (in_rd_data),
    .in_rd_addr   (in_rd_addr),
    .in_mem_addr  (in_mem_addr),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rd_data  (out_rd_data),
    .out_rd_addr  (out_rd_addr),
    .out_mem_addr (out_mem_addr),
    .out_op       (out_op),
`ifdef EX_MEM_PERF_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .occupancy    (occupancy)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input int n);
    mk.rd_data  = d;
    mk.rd_addr  = 5'(n);
    mk.mem_addr = 32'h1000 + 32'(n * 4);
    mk.op       = 6'(n);
  endfunction

  task automatic drive(input beat_t b);
    in_rd_data  = b.rd_data;
    in_rd_addr  = b.rd_addr;
    in_mem_addr = b.mem_addr;
    in_op       = b.op;
  endtask

  // Offer one beat for one cycle; check ready/occupancy mid-cycle and record it if it should be kept.
  task automatic offer(input beat_t b, input logic exp_rdy, input logic [1:0] exp_occ,
                       input logic keep);
    in_valid = 1'b1;
    drive(b);
    @(negedge clk);
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("occupancy", 128'(occupancy), 128'(exp_occ));
    if (keep) sb.push_back(b);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every MEM-side handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && rdy && out_valid && out_ready) begin
      mon_got = '{rd_data: out_rd_data, rd_addr: out_rd_addr,
                  mem_addr: out_mem_addr, op: out_op};
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %0h want none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        chk("beat", 128'(mon_got), 128'(mon_exp));
      end
    end
  end

  initial begin
    beat_t a, b, c;
    rst       = 1'b1;
    rdy       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    drive(mk(32'hDEAD, 3));
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_op", 128'(out_op), 128'(6'd0));
    chk("rst_occupancy", 128'(occupancy), 128'(2'd0));
    chk("rst_rd_data", 128'(out_rd_data), 128'(32'd0));
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    // Streaming with MEM always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(mk(32'h100 + 32'(i), i), 1'b1, (i == 1) ? 2'd0 : 2'd1, 1'b1);
      chk("stream_valid", 128'(out_valid), 128'(1'b1));
      chk("stream_addr", 128'(out_rd_addr), 128'(5'(i)));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_occ", 128'(occupancy), 128'(2'd0));
    chk("stream_drain_valid", 128'(out_valid), 128'(1'b0));
    chk("stream_sb_empty", 128'(sb.size()), 128'(0));

    // Backpressure: A held, B into skid, C refused until drained.
    out_ready = 1'b0;
    a = mk(32'hAAAA, 10);
    b = mk(32'hBBBB, 11);
    c = mk(32'hCCCC, 12);
    offer(a, 1'b1, 2'd0, 1'b1);
    offer(b, 1'b1, 2'd1, 1'b1);
    offer(c, 1'b0, 2'd2, 1'b0);
    chk("bp_main_is_a", 128'(out_rd_data), 128'(32'hAAAA));
    out_ready = 1'b1;
    offer(c, 1'b0, 2'd2, 1'b0);
    chk("bp_main_is_b", 128'(out_rd_data), 128'(32'hBBBB));
    offer(c, 1'b1, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("bp_occ_end", 128'(occupancy), 128'(2'd0));

    // Flush at occupancy 2 with D offered.
    out_ready = 1'b0;
    offer(mk(32'h2020, 20), 1'b1, 2'd0, 1'b1);
    offer(mk(32'h2121, 21), 1'b1, 2'd1, 1'b1);
    flush = 1'b1;
    offer(mk(32'hDDDD, 22), 1'b0, 2'd2, 1'b0);
    sb.delete();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", 128'(occupancy), 128'(2'd0));
    chk("fl_valid", 128'(out_valid), 128'(1'b0));
    chk("fl_rd_addr", 128'(out_rd_addr), 128'(5'd0));
    chk("fl_op", 128'(out_op), 128'(6'd0));
    chk("fl_in_ready", 128'(in_ready), 128'(1'b1));
`ifdef EX_MEM_PERF_EN
    chk("flush_cnt1", 128'(flush_cnt), 128'(16'd1));
`endif

    // Flush at occupancy 1: E consumed in the flush cycle, F dropped despite in_fire.
    offer(mk(32'hEEEE, 23), 1'b1, 2'd0, 1'b1);
    out_ready = 1'b1;
    flush     = 1'b1;
    offer(mk(32'hFFFF, 24), 1'b1, 2'd1, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_occ", 128'(occupancy), 128'(2'd0));
    chk("fl2_valid", 128'(out_valid), 128'(1'b0));
    repeat (3) tick();
`ifdef EX_MEM_PERF_EN
    chk("flush_cnt2", 128'(flush_cnt), 128'(16'd2));
`endif

    // rdy=0 freezes everything, including flush and a new beat.
    out_ready = 1'b0;
    offer(mk(32'h6666, 25), 1'b1, 2'd0, 1'b1);
    rdy       = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(mk(32'h7777, 26));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_occ", 128'(occupancy), 128'(2'd1));
      chk("frz_valid", 128'(out_valid), 128'(1'b1));
      chk("frz_data", 128'(out_rd_data), 128'(32'h6666));
      chk("frz_in_ready", 128'(in_ready), 128'(1'b1));
    end
    rdy      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("frz_resume_occ", 128'(occupancy), 128'(2'd0));

    // Simultaneous in/out fire at occupancy 1.
    out_ready = 1'b1;
    offer(mk(32'h8888, 27), 1'b1, 2'd0, 1'b1);
    offer(mk(32'h9999, 28), 1'b1, 2'd1, 1'b1);
    in_valid = 1'b0;
    chk("sim_occ", 128'(occupancy), 128'(2'd1));
    chk("sim_data", 128'(out_rd_data), 128'(32'h9999));
    tick();
    chk("sim_occ_end", 128'(occupancy), 128'(2'd0));

    repeat (3) tick();
    chk("final_sb_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
